gigatron_video_out: RTL and testbench
=====================================

// Module: gigatron_video_out
// PURPOSE
//  Converts the raw Gigatron OUT port (RRGGBB + active-low hsync/vsync) into a clean VGA stream for the
//  MiSTer video path. Outputs are registered, colour is expanded to OUT_W bits per channel, and blanking is
//  regenerated from sync edges with porch counters. A sync-loss watchdog forces blank when the CPU stops
//  producing hsync. Sits between the Gigatron core and the emu top's VGA_* / VGA_DE outputs.
// PARAMETERS
//  OUT_W      8    bits per colour channel out (2..12)
//  H_BP       12   pix_ce ticks from hsync_n rise to first active pixel
//  H_ACT      160  active pixels per line
//  V_BP       33   lines from vsync_n rise to first active line
//  V_ACT      480  active lines per frame
//  H_TIMEOUT  400  pix_ce ticks without hsync_n rise before sync_lost (must be > H_BP+H_ACT)
// PORTS
//  clk_sys    in   1      system clock
//  reset      in   1      synchronous, active-high
//  pix_ce     in   1      one-cycle Gigatron clock enable (6.25 MHz rate)
//  out_port   in   8      [1:0]R [3:2]G [5:4]B [6]hsync_n [7]vsync_n
//  vga_r/g/b  out  OUT_W  expanded colour, zero while blanked
//  vga_hs_n   out  1      registered out_port[6]
//  vga_vs_n   out  1      registered out_port[7]
//  hblank     out  1      horizontal blank
//  vblank     out  1      vertical blank
//  ce_pix     out  1      pix_ce delayed one clk_sys, aligned with outputs
//  sync_lost  out  1      watchdog flag
// BEHAVIOUR
//  - Reset: colours 0, vga_hs_n=1, vga_vs_n=1, hblank=1, vblank=1, ce_pix=0, sync_lost=1, counters 0, prev syncs 1.
//  - All state advances only on clk_sys edges where pix_ce=1; outputs valid 1 clk_sys after that edge.
//  - hcnt: cleared on hsync_n rise (prev 0, now 1); else +1, saturating at 2^$clog2(H_TIMEOUT+1)-1.
//  - vcnt: cleared on vsync_n rise; else +1 on each hsync_n rise, saturating at all-ones.
//  - Simultaneous hsync_n and vsync_n rise: vcnt=0 and hcnt=0 (vsync clear wins over line increment).
//  - hblank = (hcnt<H_BP)|(hcnt>=H_BP+H_ACT)|~hsync_n ; vblank = (vcnt<V_BP)|(vcnt>=V_BP+V_ACT)|~vsync_n
//    | sync_lost. Evaluated on post-update counter values.
//  - Watchdog: sync_lost set when hcnt reaches H_TIMEOUT; cleared on next hsync_n rise. hcnt stays saturated.
//  - Colour expansion: 2-bit c replicated MSB-first and truncated to OUT_W ({c,c,c,...}[top OUT_W]);
//    OUT_W=8, c=2'b10 -> 8'hAA; c=2'b11 -> 8'hFF; OUT_W=3, c=2'b01 -> 3'b010.
//  - Colours forced to 0 whenever hblank|vblank (post-update) is 1.
//  - pix_ce=0: all outputs hold, except ce_pix=0.
//  - Reset mid-frame: immediate return to reset state; blank until next vsync_n rise plus V_BP lines.
// CONFIGURATION
//  GIGATRON_VIDEO_SCANLINE_EN defined: on active lines with vcnt[0]=1, each expanded channel is shifted
//  right by 1 (halved); 8'hFF -> 8'h7F. Undefined: all active lines at full intensity, no extra logic.
// STRUCTURE
//  - Package gigatron_video_pkg: OUT port bit-position localparams (R_LSB, G_LSB, B_LSB, HS_BIT, VS_BIT),
//    default VGA-at-6.25MHz timing constants, colour-expansion function.
//  - One sub-module gigatron_color_expand #(OUT_W): combinational 2->OUT_W replicator, instanced x3.
//  - Timing counters, edge detect, watchdog and output registers live in gigatron_video_out.
// TESTING
//  1 Reset held 3 clk, then pix_ce every 4 clk, no sync edges -> hblank=vblank=1, sync_lost=1, colours 0.
//  2 Full 200-tick x 525-line frame, out_port=8'b11_10_01_00 in active area -> active region 160x480;
//    vga_b/g/r = 8'hAA/8'h55/8'h00 (OUT_W=8), 0 in porches.
//  3 hsync_n and vsync_n rise on same pix_ce -> next tick hcnt=1, vcnt=0; vblank=1 for 33 lines.
//  4 Stop hsync for 400 ticks -> sync_lost=1 at tick 400, all blank; next hsync_n rise -> sync_lost=0.
//  5 pix_ce low for 10 clk mid-line -> outputs frozen, ce_pix=0; resume -> counts continue exactly.
//  6 OUT_W=3 and GIGATRON_VIDEO_SCANLINE_EN: c=2'b11 -> 3'b111 on even lines, 3'b011 on odd lines.

Source files
------------

// File: rtl/gigatron_video_pkg.sv
// Shared definitions for the Gigatron video output path: OUT port bit
// positions, default VGA-at-6.25MHz timing and the colour replication helper.
package gigatron_video_pkg;

  // OUT port layout: [1:0]R [3:2]G [5:4]B [6]hsync_n [7]vsync_n
  localparam int R_LSB  = 0;
  localparam int G_LSB  = 2;
  localparam int B_LSB  = 4;
  localparam int HS_BIT = 6;
  localparam int VS_BIT = 7;

  // Default timing, counted in pix_ce ticks (horizontal) and lines (vertical)
  localparam int DEF_OUT_W     = 8;
  localparam int DEF_H_BP      = 12;
  localparam int DEF_H_ACT     = 160;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_V_ACT     = 480;
  localparam int DEF_H_TIMEOUT = 400;

  // Widest supported channel; the replicated pattern is built at this width
  localparam int EXP_MAX_W = 12;

  // Replicate a 2-bit colour MSB-first across the widest channel width
  function automatic logic [EXP_MAX_W-1:0] expand_color(input logic [1:0] c);
    return {6{c}};
  endfunction

endpackage

// File: rtl/gigatron_video_if.sv
// Gigatron OUT port in, conditioned VGA stream out.
// master: the Gigatron core side; slave: gigatron_video_out.
interface gigatron_video_if #(
  parameter int OUT_W = 8
);
  logic             pix_ce;
  logic [7:0]       out_port;
  logic [OUT_W-1:0] vga_r;
  logic [OUT_W-1:0] vga_g;
  logic [OUT_W-1:0] vga_b;
  logic             vga_hs_n;
  logic             vga_vs_n;
  logic             hblank;
  logic             vblank;
  logic             ce_pix;
  logic             sync_lost;

  modport master (
    output pix_ce, out_port,
    input  vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n, hblank, vblank, ce_pix, sync_lost
  );

  modport slave (
    input  pix_ce, out_port,
    output vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n, hblank, vblank, ce_pix, sync_lost
  );
endinterface

// File: rtl/gigatron_color_expand.sv
// Combinational 2-bit to OUT_W-bit colour replicator: the top OUT_W bits of
// {c,c,c,...}, so 2'b11 gives full scale and 2'b00 gives zero.
module gigatron_color_expand
  import gigatron_video_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [1:0]       c_i,
  output logic [OUT_W-1:0] c_o
);

  logic [EXP_MAX_W-1:0] full_s;

  assign full_s = expand_color(c_i);
  assign c_o    = OUT_W'(full_s >> (EXP_MAX_W - OUT_W));

endmodule

// File: rtl/gigatron_video_out.sv
// Gigatron OUT port to VGA conditioner. Registers sync and colour, regenerates
// blanking from sync rising edges with back-porch counters, and raises a
// watchdog flag (forcing blank) when hsync stops arriving.
// Optional feature: define GIGATRON_VIDEO_SCANLINE_EN to halve the intensity
// of odd active lines (scanline effect).
module gigatron_video_out
  import gigatron_video_pkg::*;
#(
  parameter int OUT_W     = DEF_OUT_W,
  parameter int H_BP      = DEF_H_BP,
  parameter int H_ACT     = DEF_H_ACT,
  parameter int V_BP      = DEF_V_BP,
  parameter int V_ACT     = DEF_V_ACT,
  parameter int H_TIMEOUT = DEF_H_TIMEOUT
) (
  input  logic            clk_sys,
  input  logic            reset,
  gigatron_video_if.slave vid
);

  // hcnt must be able to reach H_TIMEOUT; vcnt must hold the last active line
  localparam int HW = $clog2(H_TIMEOUT + 1);
  localparam int VW = $clog2(V_BP + V_ACT + 1);

  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [HW-1:0] H_ACT_LO = HW'(H_BP);
  localparam logic [HW-1:0] H_ACT_HI = HW'(H_BP + H_ACT);
  localparam logic [HW-1:0] H_LIMIT  = HW'(H_TIMEOUT);
  localparam logic [HW-1:0] H_MAX    = {HW{1'b1}};
  localparam logic [VW-1:0] V_ONE    = VW'(1);
  localparam logic [VW-1:0] V_ACT_LO = VW'(V_BP);
  localparam logic [VW-1:0] V_ACT_HI = VW'(V_BP + V_ACT);
  localparam logic [VW-1:0] V_MAX    = {VW{1'b1}};

  logic             hs_s, vs_s, hrise_s, vrise_s, blank_s;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic [VW-1:0]    vcnt_q, vcnt_d;
  logic             hs_prev_q, vs_prev_q;
  logic             sync_lost_q, sync_lost_d;
  logic             hblank_q, hblank_d, vblank_q, vblank_d;
  logic [OUT_W-1:0] exp_r_s, exp_g_s, exp_b_s;
  logic [OUT_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic             vga_hs_q, vga_vs_q, ce_pix_q;

  assign hs_s    = vid.out_port[HS_BIT];
  assign vs_s    = vid.out_port[VS_BIT];
  assign hrise_s = ~hs_prev_q & hs_s;
  assign vrise_s = ~vs_prev_q & vs_s;

  gigatron_color_expand #(.OUT_W(OUT_W)) u_exp_r (.c_i(vid.out_port[R_LSB +: 2]), .c_o(exp_r_s));
  gigatron_color_expand #(.OUT_W(OUT_W)) u_exp_g (.c_i(vid.out_port[G_LSB +: 2]), .c_o(exp_g_s));
  gigatron_color_expand #(.OUT_W(OUT_W)) u_exp_b (.c_i(vid.out_port[B_LSB +: 2]), .c_o(exp_b_s));

  // Next pixel/line counters and watchdog; a vsync rise outranks the line increment
  always_comb begin
    hcnt_d      = hcnt_q;
    vcnt_d      = vcnt_q;
    sync_lost_d = sync_lost_q;
    if (hrise_s) begin
      hcnt_d = '0;
    end else if (hcnt_q != H_MAX) begin
      hcnt_d = hcnt_q + H_ONE;
    end else begin
      hcnt_d = hcnt_q;
    end
    if (vrise_s) begin
      vcnt_d = '0;
    end else if (hrise_s && (vcnt_q != V_MAX)) begin
      vcnt_d = vcnt_q + V_ONE;
    end else begin
      vcnt_d = vcnt_q;
    end
    if (hrise_s) begin
      sync_lost_d = 1'b0;
    end else if (hcnt_d >= H_LIMIT) begin
      sync_lost_d = 1'b1;
    end else begin
      sync_lost_d = sync_lost_q;
    end
  end

  // Blanking from the updated counters, then colour gated by blank (and dimmed on odd lines if enabled)
  always_comb begin
    hblank_d = (hcnt_d < H_ACT_LO) | (hcnt_d >= H_ACT_HI) | ~hs_s;
    vblank_d = (vcnt_d < V_ACT_LO) | (vcnt_d >= V_ACT_HI) | ~vs_s | sync_lost_d;
    blank_s  = hblank_d | vblank_d;
    if (blank_s) begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
    end else begin
`ifdef GIGATRON_VIDEO_SCANLINE_EN
      if (vcnt_d[0]) begin
        r_d = exp_r_s >> 1;
        g_d = exp_g_s >> 1;
        b_d = exp_b_s >> 1;
      end else begin
        r_d = exp_r_s;
        g_d = exp_g_s;
        b_d = exp_b_s;
      end
`else
      r_d = exp_r_s;
      g_d = exp_g_s;
      b_d = exp_b_s;
`endif
    end
  end

  // State and output registers; everything but ce_pix holds between pix_ce ticks
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      hcnt_q      <= '0;
      vcnt_q      <= '0;
      hs_prev_q   <= 1'b1;
      vs_prev_q   <= 1'b1;
      sync_lost_q <= 1'b1;
      hblank_q    <= 1'b1;
      vblank_q    <= 1'b1;
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      vga_hs_q    <= 1'b1;
      vga_vs_q    <= 1'b1;
      ce_pix_q    <= 1'b0;
    end else begin
      ce_pix_q <= vid.pix_ce;
      if (vid.pix_ce) begin
        hcnt_q      <= hcnt_d;
        vcnt_q      <= vcnt_d;
        hs_prev_q   <= hs_s;
        vs_prev_q   <= vs_s;
        sync_lost_q <= sync_lost_d;
        hblank_q    <= hblank_d;
        vblank_q    <= vblank_d;
        r_q         <= r_d;
        g_q         <= g_d;
        b_q         <= b_d;
        vga_hs_q    <= hs_s;
        vga_vs_q    <= vs_s;
      end
    end
  end

  assign vid.vga_r     = r_q;
  assign vid.vga_g     = g_q;
  assign vid.vga_b     = b_q;
  assign vid.vga_hs_n  = vga_hs_q;
  assign vid.vga_vs_n  = vga_vs_q;
  assign vid.hblank    = hblank_q;
  assign vid.vblank    = vblank_q;
  assign vid.ce_pix    = ce_pix_q;
  assign vid.sync_lost = sync_lost_q;

endmodule

// File: tb/tb_gigatron_video_out.sv
// Bench for gigatron_video_out: an OUT_W=8 and an OUT_W=3 instance share the
// same randomised Gigatron stream; a tick-level model of the timing rules
// predicts every output, checked every clock, plus hand-computed spot values.
module tb_gigatron_video_out;
  import gigatron_video_pkg::*;

  localparam int TB_H_BP  = 12;
  localparam int TB_H_ACT = 160;
  localparam int TB_V_BP  = 4;
  localparam int TB_V_ACT = 6;
  localparam int TB_H_TO  = 400;
  localparam int LINE_T   = 200;
  localparam int HS_LOW   = 180;
  localparam int FRAME_L  = 12;
  localparam int VS_LOW   = 10;

`ifdef GIGATRON_VIDEO_SCANLINE_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif
  localparam logic [7:0] ODD_R8 = SCAN ? 8'h7F : 8'hFF;
  localparam logic [2:0] ODD_R3 = SCAN ? 3'b011 : 3'b111;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  gigatron_video_if #(.OUT_W(8)) v8 ();
  gigatron_video_if #(.OUT_W(3)) v3 ();

  gigatron_video_out #(.OUT_W(8), .H_BP(TB_H_BP), .H_ACT(TB_H_ACT), .V_BP(TB_V_BP),
                       .V_ACT(TB_V_ACT), .H_TIMEOUT(TB_H_TO))
    dut8 (.clk_sys(clk_sys), .reset(reset), .vid(v8));
  gigatron_video_out #(.OUT_W(3), .H_BP(TB_H_BP), .H_ACT(TB_H_ACT), .V_BP(TB_V_BP),
                       .V_ACT(TB_V_ACT), .H_TIMEOUT(TB_H_TO))
    dut3 (.clk_sys(clk_sys), .reset(reset), .vid(v3));

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  // Model state: ticks since last hsync rise, lines since last vsync rise
  int m_h, m_l, h_sat, v_sat;
  bit m_ph, m_pv, m_lost;
  logic [7:0] e_r8, e_g8, e_b8;
  logic [2:0] e_r3, e_g3, e_b3;
  bit e_hs, e_vs, e_hb, e_vb, e_ce;

  function automatic int sat_of(input int n);
    int p = 1;
    while (p <= n) p = p * 2;
    return p - 1;
  endfunction

  // Bit i from the MSB takes colour bit 1,0,1,0,...
  function automatic logic [11:0] mexp(input logic [1:0] c, input int w, input bit dim);
    logic [11:0] res = '0;
    for (int i = 0; i < w; i++) res[w-1-i] = c[1 - (i % 2)];
    if (dim) res = res >> 1;
    return res;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step(input bit rst, input bit pce, input logic [7:0] op);
    bit hs, vs, hr, vr, dim;
    logic [11:0] t;
    if (rst) begin
      m_h = 0; m_l = 0; m_ph = 1; m_pv = 1; m_lost = 1;
      e_hs = 1; e_vs = 1; e_hb = 1; e_vb = 1; e_ce = 0;
      e_r8 = '0; e_g8 = '0; e_b8 = '0; e_r3 = '0; e_g3 = '0; e_b3 = '0;
    end else begin
      e_ce = pce;
      if (pce) begin
        hs = op[6]; vs = op[7];
        hr = !m_ph && hs; vr = !m_pv && vs;
        if (hr) m_h = 0; else if (m_h < h_sat) m_h++;
        if (vr) m_l = 0; else if (hr && m_l < v_sat) m_l++;
        if (hr) m_lost = 0; else if (m_h >= TB_H_TO) m_lost = 1;
        e_hb = (m_h < TB_H_BP) || (m_h >= TB_H_BP + TB_H_ACT) || !hs;
        e_vb = (m_l < TB_V_BP) || (m_l >= TB_V_BP + TB_V_ACT) || !vs || m_lost;
        dim = SCAN && ((m_l % 2) == 1);
        if (e_hb || e_vb) begin
          e_r8 = '0; e_g8 = '0; e_b8 = '0; e_r3 = '0; e_g3 = '0; e_b3 = '0;
        end else begin
          t = mexp(op[1:0], 8, dim); e_r8 = t[7:0];
          t = mexp(op[3:2], 8, dim); e_g8 = t[7:0];
          t = mexp(op[5:4], 8, dim); e_b8 = t[7:0];
          t = mexp(op[1:0], 3, dim); e_r3 = t[2:0];
          t = mexp(op[3:2], 3, dim); e_g3 = t[2:0];
          t = mexp(op[5:4], 3, dim); e_b3 = t[2:0];
        end
        e_hs = hs; e_vs = vs; m_ph = hs; m_pv = vs;
      end
    end
  endtask

  // Every-cycle comparison of both instances against the model
  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("r8", v8.vga_r, e_r8);       chk("g8", v8.vga_g, e_g8);   chk("b8", v8.vga_b, e_b8);
      chk("r3", v3.vga_r, e_r3);       chk("g3", v3.vga_g, e_g3);   chk("b3", v3.vga_b, e_b3);
      chk("hs_n", v8.vga_hs_n, e_hs);  chk("vs_n", v8.vga_vs_n, e_vs);
      chk("hblank", v8.hblank, e_hb);  chk("vblank", v8.vblank, e_vb);
      chk("ce_pix", v8.ce_pix, e_ce);  chk("sync_lost", v8.sync_lost, m_lost);
      chk("hblank3", v3.hblank, e_hb); chk("vblank3", v3.vblank, e_vb);
    end
  end

  task automatic drive(input bit pce, input logic [7:0] op);
    v8.pix_ce = pce; v3.pix_ce = pce; v8.out_port = op; v3.out_port = op;
    @(posedge clk_sys);
    model_step(reset, pce, op);
    #1;
  endtask

  task automatic tick(input logic [7:0] op, input int gap_max);
    int g = $urandom_range(0, gap_max);
    for (int i = 0; i < g; i++) drive(1'b0, 8'($urandom));
    drive(1'b1, op);
  endtask

  // One frame; fixed=1 paints the B=10 G=01 R=00 pattern and spot-checks it
  task automatic frame(input bit fixed, input int rst_line);
    logic [5:0] col;
    for (int l = 0; l < FRAME_L; l++) begin
      for (int p = 0; p < LINE_T; p++) begin
        if (l == rst_line && p == 50) begin
          reset = 1'b1;
          drive(1'($urandom), 8'($urandom));
          drive(1'($urandom), 8'($urandom));
          reset = 1'b0;
          chk("rst_mid_lost", v8.sync_lost, 1'b1);
          chk("rst_mid_vblank", v8.vblank, 1'b1);
        end
        if (fixed) col = ((l == 5 || l == 6) && p == 20) ? 6'b10_01_11 : 6'b10_01_00;
        else col = 6'($urandom);
        tick({(l < VS_LOW), (p < HS_LOW), col}, fixed ? 1 : 3);
        if (fixed) begin
          if (l == 0 && p == 1) begin chk("f_lost_clr", v8.sync_lost, 1'b0); chk("f_l0_vb", v8.vblank, 1'b1); end
          if (l == 3 && p == 12) begin chk("f_l3_vb", v8.vblank, 1'b1); chk("f_l3_b", v8.vga_b, 8'h00); end
          if (l == 4 && p == 11) chk("f_p11_hb", v8.hblank, 1'b1);
          if (l == 4 && p == 12) begin
            chk("f_b8", v8.vga_b, 8'hAA); chk("f_g8", v8.vga_g, 8'h55); chk("f_r8", v8.vga_r, 8'h00);
            chk("f_hb0", v8.hblank, 1'b0); chk("f_vb0", v8.vblank, 1'b0);
            chk("f_b3", v3.vga_b, 3'b101); chk("f_g3", v3.vga_g, 3'b010);
          end
          if (l == 5 && p == 20) begin chk("f_odd_r8", v8.vga_r, ODD_R8); chk("f_odd_r3", v3.vga_r, ODD_R3); end
          if (l == 6 && p == 20) begin chk("f_even_r8", v8.vga_r, 8'hFF); chk("f_even_r3", v3.vga_r, 3'b111); end
          if (l == 9 && p == 171) chk("f_last_px", v8.vga_b, 8'hAA);
          if (l == 9 && p == 172) begin chk("f_fp_hb", v8.hblank, 1'b1); chk("f_fp_b", v8.vga_b, 8'h00); end
          if (l == 10 && p == 50) chk("f_vs_vb", v8.vblank, 1'b1);
        end
      end
    end
  endtask

  initial begin
    logic hs, vs;
    h_sat = sat_of(TB_H_TO);
    v_sat = sat_of(TB_V_BP + TB_V_ACT);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00);
    chk_en = 1'b1;
    chk("rst_hs", v8.vga_hs_n, 1'b1); chk("rst_vs", v8.vga_vs_n, 1'b1);
    chk("rst_ce", v8.ce_pix, 1'b0);   chk("rst_lost", v8.sync_lost, 1'b1);
    chk("rst_r", v8.vga_r, 8'h00);
    reset = 1'b0;

    // pix_ce every 4 clocks, syncs low with no rising edge
    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < 3; k++) drive(1'b0, 8'($urandom));
      drive(1'b1, {2'b00, 6'($urandom)});
    end
    chk("t1_hb", v8.hblank, 1'b1); chk("t1_vb", v8.vblank, 1'b1);
    chk("t1_lost", v8.sync_lost, 1'b1); chk("t1_g", v8.vga_g, 8'h00);

    frame(1'b1, -1);
    frame(1'b0, -1);

    // Pause pix_ce mid-line; counting must resume exactly
    for (int p = 0; p < 100; p++) tick({1'b1, 1'b1, 6'($urandom)}, 1);
    for (int i = 0; i < 10; i++) drive(1'b0, 8'($urandom));
    chk("pause_ce", v8.ce_pix, 1'b0);
    for (int p = 100; p < LINE_T; p++) tick({1'b1, (p < HS_LOW), 6'($urandom)}, 1);

    // Watchdog: one rise, then no further rises past saturation
    for (int k = 0; k < 530; k++) begin
      tick({2'b11, 6'($urandom)}, 1);
      if (k == 399) chk("wd_399", v8.sync_lost, 1'b0);
      if (k == 400) begin chk("wd_400", v8.sync_lost, 1'b1); chk("wd_vb", v8.vblank, 1'b1); end
    end
    chk("wd_sat_b", v8.vga_b, 8'h00);
    for (int k = 0; k < 3; k++) tick({2'b10, 6'($urandom)}, 1);
    tick({2'b11, 6'($urandom)}, 1);
    chk("wd_clear", v8.sync_lost, 1'b0);

    frame(1'b0, 6);
    frame(1'b0, -1);

    // Random sync activity
    hs = 1'b1; vs = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 7) == 0) hs = ~hs;
      if ($urandom_range(0, 63) == 0) vs = ~vs;
      tick({vs, hs, 6'($urandom)}, 2);
    end

    @(posedge clk_sys);
    #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
